// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter sharing one MemoryController between the I-fetch miss path and the LSU.
// Optional abandon-on-timeout in WAIT is compiled in with `define ARB_TIMEOUT_EN.
module mem_request_arbiter #(
  parameter int addressSize   = 64,
  parameter int blockSize     = 256,
  parameter int timeoutCycles = 1024,
  parameter int timeoutWidth  = 10
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   iReq_i,
  input  logic [addressSize-1:0] iAddress_i,
  output logic                   iAck_o,
  output logic                   iBlockValid_o,
  input  logic                   dReq_i,
  input  logic [addressSize-1:0] dAddress_i,
  input  logic [blockSize-1:0]   dData_i,
  input  logic                   dIsWrite_i,
  output logic                   dAck_o,
  output logic                   dBlockValid_o,
  output logic [blockSize-1:0]   block_o,
  output logic [addressSize-1:0] blockAddress_o,
  output logic [addressSize-1:0] mcAddress_o,
  output logic [blockSize-1:0]   mcData_o,
  output logic                   mcRequestEnable_o,
  output logic                   mcIsMemWrite_o,
  input  logic [blockSize-1:0]   mcBlock_i,
  input  logic [addressSize-1:0] mcBlockAddress_i,
  input  logic                   mcBlockOutEnable_i,
  input  logic                   mcIsMemoryEngaged_i,
  output logic                   busy_o,
  output logic                   grantIsData_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_reg;
  logic   last_served_d_reg;  // 1 when D owned the most recently completed grant
  logic   flushed_reg;

`ifdef ARB_TIMEOUT_EN
  localparam logic [timeoutWidth-1:0] term_count = timeoutWidth'(timeoutCycles - 1);
  logic [timeoutWidth-1:0] wait_count_reg;
`else
  localparam logic timeout_cfg_unused = ((64'd1 << timeoutWidth) >= 64'(timeoutCycles));
`endif

  // On a tie the requester that was not served last wins.
  logic pick_d;
  logic flush_hit;
  assign pick_d    = dReq_i & (~iReq_i | ~last_served_d_reg);
  assign flush_hit = flush_i & ~grantIsData_o;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg         <= IDLE;
      last_served_d_reg <= 1'b0;
      flushed_reg       <= 1'b0;
      iAck_o            <= 1'b0;
      dAck_o            <= 1'b0;
      iBlockValid_o     <= 1'b0;
      dBlockValid_o     <= 1'b0;
      block_o           <= '0;
      blockAddress_o    <= '0;
      mcAddress_o       <= '0;
      mcData_o          <= '0;
      mcRequestEnable_o <= 1'b0;
      mcIsMemWrite_o    <= 1'b0;
      busy_o            <= 1'b0;
      grantIsData_o     <= 1'b0;
      timeout_o         <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_count_reg    <= '0;
`endif
    end else begin
      iAck_o            <= 1'b0;
      dAck_o            <= 1'b0;
      iBlockValid_o     <= 1'b0;
      dBlockValid_o     <= 1'b0;
      mcRequestEnable_o <= 1'b0;
      timeout_o         <= 1'b0;

      case (state_reg)
        IDLE: begin
          flushed_reg <= 1'b0;
          if ((iReq_i | dReq_i) && !mcIsMemoryEngaged_i) begin
            state_reg         <= ISSUE;
            busy_o            <= 1'b1;
            grantIsData_o     <= pick_d;
            mcAddress_o       <= pick_d ? dAddress_i : iAddress_i;
            mcData_o          <= pick_d ? dData_i : '0;
            mcIsMemWrite_o    <= pick_d & dIsWrite_i;
            mcRequestEnable_o <= 1'b1;
            iAck_o            <= ~pick_d;
            dAck_o            <= pick_d;
          end
        end

        ISSUE: begin
          state_reg <= WAIT;
          if (flush_hit) flushed_reg <= 1'b1;
`ifdef ARB_TIMEOUT_EN
          wait_count_reg <= '0;
`endif
        end

        WAIT: begin
          if (mcBlockOutEnable_i) begin
            block_o           <= mcBlock_i;
            blockAddress_o    <= mcBlockAddress_i;
            dBlockValid_o     <= grantIsData_o;
            // A flush seen at any point of an I grant, including this edge, drops the return.
            iBlockValid_o     <= ~grantIsData_o & ~flushed_reg & ~flush_i;
            last_served_d_reg <= grantIsData_o;
            state_reg         <= IDLE;
            busy_o            <= 1'b0;
            flushed_reg       <= 1'b0;
          end else begin
            if (flush_hit) flushed_reg <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            if (wait_count_reg == term_count) begin
              timeout_o   <= 1'b1;
              state_reg   <= IDLE;
              busy_o      <= 1'b0;
              flushed_reg <= 1'b0;
            end else begin
              wait_count_reg <= wait_count_reg + 1'b1;
            end
`endif
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule
